// File: rtl/ren_simd_arb.sv
// ren_simd_arb: arbitrates NREQ requesters onto one FP_SIMD unit (IDLE/BUSY/FLUSH).
// Define REN_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module ren_simd_arb #(
  parameter int NREQ  = 3,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        i_req,
  input  logic [3*NREQ-1:0]      i_opcode,
  input  logic [22*LANES*NREQ-1:0] i_in1,
  input  logic [22*LANES*NREQ-1:0] i_in2,
  output logic [NREQ-1:0]        o_gnt,
  output logic [NREQ-1:0]        o_valid,
  output logic [22*LANES-1:0]    o_result,
  output logic [1:0]             o_owner,
  output logic                   o_busy,
  output logic                   o_simd_en,
  output logic                   o_simd_rstn,
  output logic [22*LANES-1:0]    o_simd_in1,
  output logic [22*LANES-1:0]    o_simd_in2,
  output logic [2:0]             o_simd_opcode,
  input  logic [22*LANES-1:0]    i_simd_out,
  input  logic                   i_simd_valid,
  input  logic                   i_simd_busy
);
  localparam int W = 22 * LANES;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FLUSH = 2'd2} state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_owner, w_win;
  logic [NREQ-1:0] r_gnt, r_valid;
  logic [W-1:0]    r_result, r_in1, r_in2;
  logic [2:0]      r_op;
  logic            w_grant, w_capture;
  logic            w_unused;
  assign w_unused = &{1'b0, i_simd_busy};
`ifdef REN_ARB_ROUND_ROBIN_EN
  logic [1:0] r_ptr;
  // descending scan: the last hit is the nearest index above the pointer
  always_comb begin
    w_win = '0;
    for (int i = NREQ; i >= 1; i--)
      if (i_req[(int'(r_ptr) + i) % NREQ]) w_win = 2'((int'(r_ptr) + i) % NREQ);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_ptr <= 2'(NREQ - 1);
    else if (w_grant) r_ptr <= w_win;
`else
  always_comb begin
    w_win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (i_req[i]) w_win = 2'(i);
  end
`endif
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: if (|i_req) begin
        w_grant = 1'b1;
        w_next  = BUSY;
      end
      BUSY: if (i_simd_valid) begin
        w_capture = 1'b1;
        w_next    = FLUSH;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_valid  <= '0;
      r_result <= '0;
      r_owner  <= '0;
      r_in1    <= '0;
      r_in2    <= '0;
      r_op     <= '0;
    end else begin
      r_state  <= w_next;
      r_gnt    <= w_grant ? ONE << w_win : '0;
      r_valid  <= w_capture ? ONE << r_owner : '0;
      r_result <= w_capture ? i_simd_out : r_result;
      r_owner  <= w_grant ? w_win : r_owner;
      r_in1    <= w_grant ? i_in1[int'(w_win)*W +: W] : r_in1;
      r_in2    <= w_grant ? i_in2[int'(w_win)*W +: W] : r_in2;
      r_op     <= w_grant ? i_opcode[int'(w_win)*3 +: 3] : r_op;
    end
  assign o_gnt         = r_gnt;
  assign o_valid       = r_valid;
  assign o_result      = r_result;
  assign o_owner       = r_owner;
  assign o_busy        = r_state != IDLE;
  assign o_simd_en     = r_state == BUSY;
  assign o_simd_rstn   = r_state == BUSY;
  assign o_simd_in1    = r_in1;
  assign o_simd_in2    = r_in2;
  assign o_simd_opcode = r_op;
endmodule

// File: tb/tb_ren_simd_arb.sv
// tb_ren_simd_arb: directed bench for ren_simd_arb with a 4-cycle FP_SIMD model.
// Expectations follow REN_ARB_ROUND_ROBIN_EN when the macro is defined.
module tb_ren_simd_arb;
  localparam logic [2:0]  OP_MUL = 3'd2;
  localparam logic [87:0] L2   = {4{22'h100000}};
  localparam logic [87:0] L3   = {4{22'h101000}};
  localparam logic [87:0] L6   = {4{22'h103000}};
  localparam logic [87:0] L1_5 = {4{22'h0FF000}};
  localparam logic [87:0] L4_5 = {4{22'h102400}};
  localparam logic [87:0] JUNK = {4{22'h2ABCDE}};

  logic         clk = 1'b0, rstn = 1'b0;
  logic [2:0]   i_req = '0;
  logic [8:0]   i_opcode = '0;
  logic [263:0] i_in1 = '0, i_in2 = '0;
  logic [2:0]   o_gnt, o_valid;
  logic [87:0]  o_result, o_simd_in1, o_simd_in2, i_simd_out;
  logic [1:0]   o_owner;
  logic         o_busy, o_simd_en, o_simd_rstn, i_simd_valid;
  logic [2:0]   o_simd_opcode;
  int errors = 0, checks = 0;

  logic [3:0]  m_cnt = '0;
  logic        m_valid = 1'b0, spur = 1'b0;
  logic [87:0] m_out = '0, spur_out = '0;

  ren_simd_arb dut (
    .clk(clk), .rstn(rstn), .i_req(i_req), .i_opcode(i_opcode), .i_in1(i_in1), .i_in2(i_in2),
    .o_gnt(o_gnt), .o_valid(o_valid), .o_result(o_result), .o_owner(o_owner), .o_busy(o_busy),
    .o_simd_en(o_simd_en), .o_simd_rstn(o_simd_rstn), .o_simd_in1(o_simd_in1),
    .o_simd_in2(o_simd_in2), .o_simd_opcode(o_simd_opcode), .i_simd_out(i_simd_out),
    .i_simd_valid(i_simd_valid), .i_simd_busy(1'b0));

  always #5 clk = ~clk;

  // 22-bit float: sign[21], exponent[20:13] bias 127, mantissa[12:0]; normals only
  function automatic logic [21:0] fmul22(input logic [21:0] a, input logic [21:0] b);
    logic [27:0] m;
    logic [8:0]  e;
    m = 28'({1'b1, a[12:0]}) * 28'({1'b1, b[12:0]});
    e = 9'(a[20:13]) + 9'(b[20:13]) - 9'd127;
    if (m[27]) begin
      m = m >> 1;
      e = e + 9'd1;
    end
    return {a[21] ^ b[21], e[7:0], m[25:13]};
  endfunction

  function automatic logic [87:0] simd_fn(input logic [2:0] op, input logic [87:0] a, input logic [87:0] b);
    logic [87:0] r;
    for (int l = 0; l < 4; l++)
      r[22*l +: 22] = (op == OP_MUL) ? fmul22(a[22*l +: 22], b[22*l +: 22]) : a[22*l +: 22];
    return r;
  endfunction

  always @(posedge clk)
    if (!o_simd_rstn) begin
      m_cnt   <= '0;
      m_valid <= 1'b0;
    end else begin
      m_cnt   <= m_cnt + 4'd1;
      m_valid <= m_cnt == 4'd3;
      if (m_cnt == 4'd3) m_out <= simd_fn(o_simd_opcode, o_simd_in1, o_simd_in2);
    end
  assign i_simd_valid = m_valid | spur;
  assign i_simd_out   = spur ? spur_out : m_out;

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%b want 0", tag, o_busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    checks++; if (o_gnt !== 3'b000 || o_valid !== 3'b000) begin errors++; $display("FAIL reset_pulses gnt=%b valid=%b want 000/000", o_gnt, o_valid); end
    checks++; if (o_result !== 88'd0 || o_owner !== 2'd0) begin errors++; $display("FAIL reset_result result=%h owner=%0d want 0/0", o_result, o_owner); end
    checks++; if ({o_busy, o_simd_en, o_simd_rstn} !== 3'b000) begin errors++; $display("FAIL reset_ctrl busy/en/rstn=%b want 000", {o_busy, o_simd_en, o_simd_rstn}); end
    checks++; if (o_simd_in1 !== 88'd0 || o_simd_in2 !== 88'd0 || o_simd_opcode !== 3'd0) begin errors++; $display("FAIL reset_operands in1=%h in2=%h op=%0d want 0", o_simd_in1, o_simd_in2, o_simd_opcode); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single();
    int n = 0;
    @(negedge clk);
    i_req = 3'b001; i_opcode[2:0] = OP_MUL; i_in1[87:0] = L2; i_in2[87:0] = L3;
    @(negedge clk);
    checks++; if (o_gnt !== 3'b001 || o_owner !== 2'd0) begin errors++; $display("FAIL single_gnt gnt=%b owner=%0d want 001/0", o_gnt, o_owner); end
    checks++; if ({o_busy, o_simd_en, o_simd_rstn} !== 3'b111 || o_simd_in1 !== L2 || o_simd_opcode !== OP_MUL) begin errors++; $display("FAIL single_busy ctrl=%b in1=%h op=%0d want 111/%h/%0d", {o_busy, o_simd_en, o_simd_rstn}, o_simd_in1, o_simd_opcode, L2, OP_MUL); end
    i_req = 3'b000;
    while (o_valid === 3'b000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL single_latency cycles=%0d want 5", n); end
    checks++; if (o_valid !== 3'b001 || o_result !== L6) begin errors++; $display("FAIL single_result valid=%b result=%h want 001/%h", o_valid, o_result, L6); end
    checks++; if ({o_busy, o_simd_en, o_simd_rstn} !== 3'b100) begin errors++; $display("FAIL single_flush busy/en/rstn=%b want 100", {o_busy, o_simd_en, o_simd_rstn}); end
    @(negedge clk);
    checks++; if (o_busy !== 1'b0 || o_valid !== 3'b000) begin errors++; $display("FAIL single_idle busy=%b valid=%b want 0/000", o_busy, o_valid); end
  endtask

  task automatic test_spurious_valid();
    @(negedge clk);
    spur = 1'b1; spur_out = JUNK;
    @(negedge clk);
    checks++; if (o_valid !== 3'b000 || o_result !== L6) begin errors++; $display("FAIL spurious_a valid=%b result=%h want 000/%h", o_valid, o_result, L6); end
    spur = 1'b0;
    @(negedge clk);
    checks++; if (o_valid !== 3'b000 || o_result !== L6 || o_busy !== 1'b0) begin errors++; $display("FAIL spurious_b valid=%b result=%h busy=%b want 000/%h/0", o_valid, o_result, o_busy, L6); end
  endtask

  task automatic test_operand_latch();
    int n = 0;
    logic bad = 1'b0;
    @(negedge clk);
    i_req = 3'b010; i_opcode[5:3] = OP_MUL; i_in1[175:88] = L1_5; i_in2[175:88] = L3;
    @(negedge clk);
    checks++; if (o_gnt !== 3'b010 || o_owner !== 2'd1) begin errors++; $display("FAIL latch_gnt gnt=%b owner=%0d want 010/1", o_gnt, o_owner); end
    i_in1[175:88] = JUNK; i_req = 3'b000;
    while (o_valid === 3'b000 && n < 20) begin
      if (o_simd_in1 !== L1_5) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL latch_hold in1_changed=%b want 0", bad); end
    checks++; if (o_valid !== 3'b010 || o_result !== L4_5) begin errors++; $display("FAIL latch_result valid=%b result=%h want 010/%h", o_valid, o_result, L4_5); end
    wait_idle("latch");
  endtask

  task automatic test_arbitration();
    logic [2:0] g[4];
    logic [1:0] o[4];
    logic [2:0] eg[4];
    logic [1:0] eo[4];
    int k = 0, n = 0;
`ifdef REN_ARB_ROUND_ROBIN_EN
    eg = '{3'b001, 3'b010, 3'b100, 3'b001};
    eo = '{2'd0, 2'd1, 2'd2, 2'd0};
`else
    eg = '{3'b001, 3'b001, 3'b001, 3'b001};
    eo = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    do_reset();
    i_req = 3'b111; i_opcode = {3{OP_MUL}}; i_in1 = {3{L2}}; i_in2 = {3{L3}};
    while (k < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (o_gnt !== 3'b000) begin
        g[k] = o_gnt; o[k] = o_owner; k++;
      end
    end
    i_req = 3'b000;
    checks++; if (k != 4) begin errors++; $display("FAIL arb_count grants=%0d want 4", k); end
    for (int j = 0; j < k; j++) begin
      checks++;
      if (g[j] !== eg[j] || o[j] !== eo[j]) begin errors++; $display("FAIL arb_grant%0d gnt=%b owner=%0d want %b/%0d", j, g[j], o[j], eg[j], eo[j]); end
    end
    wait_idle("arb");
  endtask

  task automatic test_reset_mid_busy();
    logic seen = 1'b0;
    @(negedge clk);
    i_req = 3'b001; i_opcode[2:0] = OP_MUL; i_in1[87:0] = L2; i_in2[87:0] = L3;
    @(negedge clk);
    checks++; if (o_gnt !== 3'b001) begin errors++; $display("FAIL abort_gnt gnt=%b want 001", o_gnt); end
    i_req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if ({o_busy, o_simd_en, o_simd_rstn, o_gnt, o_valid, o_owner} !== 11'd0 || o_result !== 88'd0 || o_simd_in1 !== 88'd0) begin errors++; $display("FAIL abort_clear ctrl=%b result=%h in1=%h want 0", {o_busy, o_simd_en, o_simd_rstn, o_gnt, o_valid, o_owner}, o_result, o_simd_in1); end
    @(negedge clk);
    rstn = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (o_valid !== 3'b000 || o_busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid activity=%b want 0", seen); end
    i_req = 3'b100; i_opcode[8:6] = OP_MUL; i_in1[263:176] = L2; i_in2[263:176] = L3;
    @(negedge clk);
    checks++; if (o_gnt !== 3'b100 || o_owner !== 2'd2) begin errors++; $display("FAIL abort_regrant gnt=%b owner=%0d want 100/2", o_gnt, o_owner); end
    i_req = 3'b000;
    wait_idle("abort");
    checks++; if (o_result !== L6) begin errors++; $display("FAIL abort_result result=%h want %h", o_result, L6); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_spurious_valid();
    test_operand_latch();
    test_arbitration();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ren_simd_arb.md
REN_SIMD_ARB -- requirements
Module: ren_simd_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, giving the number of requesters sharing one FP_SIMD unit (range 2..4).
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of 22-bit floating-point lanes.
REQ-003 Ports SHALL be as follows:
- clk  input  1  — the single clock.
- rstn  input  1  — asynchronous, active-low reset.
- i_req  input  NREQ  — request per requester, level.
- i_opcode  input  3*NREQ  — opcode per requester; requester k uses bits [3k+2:3k].
- i_in1  input  88*NREQ  — operand A per requester; requester k uses bits [88k+87:88k].
- i_in2  input  88*NREQ  — operand B per requester, same slicing as i_in1.
- o_gnt  output  NREQ  — one-cycle grant pulse, one-hot.
- o_valid  output  NREQ  — one-cycle result-valid pulse, one-hot.
- o_result  output  88  — registered result, shared by all requesters.
- o_owner  output  2  — index of the current or last owner.
- o_busy  output  1  — high when the state is not IDLE.
- o_simd_en  output  1  — FP_SIMD enable.
- o_simd_rstn  output  1  — FP_SIMD reset, active-low.
- o_simd_in1  output  88  — latched operand A to FP_SIMD.
- o_simd_in2  output  88  — latched operand B to FP_SIMD.
- o_simd_opcode  output  3  — latched opcode to FP_SIMD.
- i_simd_out  input  88  — FP_SIMD result.
- i_simd_valid  input  1  — FP_SIMD result valid.
- i_simd_busy  input  1  — FP_SIMD busy; monitor only, not used for control.

Function
REQ-004 The FSM SHALL have three states, IDLE, BUSY and FLUSH, encoded in a 2-bit register.
REQ-005 In IDLE, if any i_req bit is high at a clock edge, the block SHALL, at that edge:
- select winner w per REQ-012;
- latch i_opcode, i_in1 and i_in2 slice w into the operand registers;
- set o_owner=w and pulse o_gnt[w] for the following cycle;
- go to BUSY.
REQ-006 Grant latency SHALL be 1 cycle from the first sampled i_req edge to o_gnt high.
REQ-007 In BUSY, o_simd_en and o_simd_rstn SHALL both be 1, and the o_simd_* operand outputs SHALL carry the latched registers, independent of the requester inputs.
REQ-008 In BUSY, when i_simd_valid=1 at an edge, the block SHALL, at that edge:
- capture i_simd_out into o_result;
- pulse o_valid[o_owner] for the following cycle;
- go to FLUSH.
REQ-009 In FLUSH, o_simd_en=0 and o_simd_rstn=0, clearing the FP_SIMD; the next edge SHALL go to IDLE unconditionally.
REQ-010 In IDLE and FLUSH, o_simd_en=0 and o_simd_rstn=0, and i_simd_valid SHALL be ignored.
REQ-011 o_result SHALL hold its value until the next capture; o_gnt and o_valid SHALL never have more than one bit set.
REQ-012 Arbitration SHALL be evaluated only in IDLE; requests arriving in BUSY or FLUSH SHALL wait. A requester dropping i_req before its grant SHALL receive no grant.
REQ-013 Requesters SHALL be free to change operands or deassert i_req after o_gnt; a requester still holding i_req after o_valid SHALL be treated as a new request.
REQ-014 Minimum issue-to-issue spacing SHALL be SIMD latency + 3 cycles (IDLE, the BUSY-exit edge, FLUSH).
REQ-015 Requester indices at or above NREQ SHALL never be granted.

Reset
REQ-016 When rstn=0, asynchronously:
- state=IDLE;
- o_gnt=0, o_valid=0, o_result=0, o_owner=0;
- operand registers=0, o_simd_opcode=0;
- o_simd_en=0, o_simd_rstn=0;
- round-robin pointer=NREQ-1, so index 0 has first priority.
REQ-017 Reset asserted in BUSY SHALL abort the operation with no o_valid pulse; after release, the block SHALL restart from IDLE.

Configuration
REQ-018 With macro REN_ARB_ROUND_ROBIN_EN defined:
- the winner SHALL be the first requesting index searching upward from pointer+1, modulo NREQ;
- the pointer SHALL update to w on each grant.
REQ-019 With REN_ARB_ROUND_ROBIN_EN undefined, the winner SHALL be the lowest requesting index (fixed priority), and no pointer register SHALL exist.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Single request: i_req=001, opcode op_mul, in1 lanes 2.0, in2 lanes 3.0, SIMD model valid after 4 cycles → o_gnt=001 one cycle after the request; o_result lanes 6.0; o_valid=001 one cycle after i_simd_valid; 1 FLUSH cycle with o_simd_rstn=0.
- Simultaneous i_req=111 held (round robin) → grants 001, 010, 100, 001 in order; o_owner=0,1,2,0.
- Simultaneous i_req=111 held (macro undefined) → every grant is 001.
- Requester changes i_in1 the cycle after o_gnt → o_simd_in1 unchanged until FLUSH; result uses the latched operands.
- rstn pulsed low mid-BUSY → all outputs 0 within the same cycle; no o_valid; a new request after release is granted normally.
- Spurious i_simd_valid in IDLE → no o_valid and o_result unchanged.
